// File: rtl/gb_camera_capture.sv
`timescale 1ns/1ps
// Game Boy Camera capture sequencer: CAM register file, exposure timer, 2bpp dither and tile-data writer.
// Latency: frame_start EXP_BASE+(exposure<<EXP_SHIFT) ce_cpu ticks after start; one byte pair per 8 pixels.
// Backpressure: pix_ready drops while a tile-row byte pair waits for cap_ack; cap_addr/cap_data hold until ack.
module gb_camera_capture #(
  parameter int unsigned EXP_BASE  = 32446,
  parameter int unsigned EXP_SHIFT = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        ce_cpu,
  input  logic        cam_sel,
  input  logic [15:0] cart_addr,
  input  logic        cart_wr,
  input  logic [7:0]  cart_di,
  output logic [7:0]  reg_do,
  output logic        busy,
  output logic        frame_start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic        cap_req,
  output logic [12:0] cap_addr,
  output logic [7:0]  cap_data,
  input  logic        cap_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXPOSE, S_FETCH, S_WR_LO, S_WR_HI, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  regs [0:53];
  logic [20:0] exp_cnt;
  logic [20:0] exp_target;
  logic [6:0]  pix_x, pix_y;
  logic [7:0]  sh_lo, sh_hi;
  logic [12:0] wr_base;
  logic        wr_last;
  logic        reg_we, start_wr, stop_wr, expose_done, pix_take;
  logic [5:0]  t_idx;
  logic [7:0]  t0, t1, t2;
  logic [1:0]  pix_v;
  logic        unused_bits;

  // Address bits 12:7 only mirror the register window.
  assign unused_bits = ^cart_addr[12:7];

  assign reg_we   = ce_cpu && cart_wr && cam_sel && (cart_addr[15:13] == 3'b101) && (cart_addr[6:0] < 7'd54);
  assign start_wr = reg_we && (cart_addr[6:0] == 7'd0) && cart_di[0];
  assign stop_wr  = reg_we && (cart_addr[6:0] == 7'd0) && !cart_di[0];

  // Exposure length in ce_cpu ticks; 21 bits holds the largest setting without overflow.
  assign exp_target  = 21'(EXP_BASE) + (21'({regs[2], regs[3]}) << EXP_SHIFT);
  assign expose_done = ce_cpu && ((exp_cnt + 21'd1) >= exp_target);

  // Threshold triple for the 4x4 dither matrix cell of the current pixel.
  assign t_idx = 6'd6 + 6'({pix_y[1:0], pix_x[1:0]}) * 6'd3;
  assign t0    = regs[t_idx];
  assign t1    = regs[t_idx + 6'd1];
  assign t2    = regs[t_idx + 6'd2];
  assign pix_v = (pix_data < t0) ? 2'd3 : (pix_data < t1) ? 2'd2 : (pix_data < t2) ? 2'd1 : 2'd0;

  assign pix_take = pix_valid && pix_ready;
  assign busy     = enable && (state != S_IDLE);
  assign cap_addr = wr_base | {12'd0, (state == S_WR_HI)};
  assign cap_data = (state == S_WR_HI) ? sh_hi : sh_lo;
  assign reg_do   = (cam_sel && (cart_addr[6:0] == 7'd0)) ? {5'd0, regs[0][2:1], busy} : 8'h00;

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and handshake outputs; enable low forces idle and silences every strobe.
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    pix_ready   = 1'b0;
    cap_req     = 1'b0;
    if (!enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start_wr) state_nxt = S_EXPOSE;
        S_EXPOSE: begin
          if (stop_wr) begin
            state_nxt = S_IDLE;
          end else if (expose_done) begin
            frame_start = 1'b1;
            state_nxt   = S_FETCH;
          end
        end
        S_FETCH: begin
          pix_ready = 1'b1;
          if (pix_valid && (pix_x[2:0] == 3'd7)) state_nxt = S_WR_LO;
        end
        S_WR_LO: begin
          cap_req = 1'b1;
          if (cap_ack) state_nxt = S_WR_HI;
        end
        S_WR_HI: begin
          cap_req = 1'b1;
          if (cap_ack) state_nxt = wr_last ? S_DONE : S_FETCH;
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // CAM register file; the capture-done cycle clears the start bit.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 54; i++) regs[i] <= 8'h00;
    end else if (!enable) begin
      for (int i = 0; i < 54; i++) regs[i] <= 8'h00;
    end else begin
      if (reg_we) regs[cart_addr[5:0]] <= cart_di;
      if (state == S_DONE) regs[0][0] <= 1'b0;
    end
  end

  // Exposure counter, raster position, bit-plane shifters and tile-row write address.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      exp_cnt <= '0;
      pix_x   <= '0;
      pix_y   <= '0;
      sh_lo   <= '0;
      sh_hi   <= '0;
      wr_base <= '0;
      wr_last <= 1'b0;
    end else if (!enable) begin
      exp_cnt <= '0;
      pix_x   <= '0;
      pix_y   <= '0;
      sh_lo   <= '0;
      sh_hi   <= '0;
      wr_base <= '0;
      wr_last <= 1'b0;
    end else begin
      if (state != S_EXPOSE) exp_cnt <= '0;
      else if (ce_cpu)       exp_cnt <= exp_cnt + 21'd1;
      if (frame_start) begin
        pix_x <= '0;
        pix_y <= '0;
      end else if (pix_take) begin
        sh_lo <= {sh_lo[6:0], pix_v[0]};
        sh_hi <= {sh_hi[6:0], pix_v[1]};
        if (pix_x[2:0] == 3'd7) begin
          wr_base <= 13'h100 + {1'b0, pix_y[6:3], pix_x[6:3], pix_y[2:0], 1'b0};
          wr_last <= (pix_x == 7'd127) && (pix_y == 7'd111);
        end
        pix_x <= pix_x + 7'd1;
        if (pix_x == 7'd127) pix_y <= pix_y + 7'd1;
      end
    end
  end

endmodule
